// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - multiplexed 8-digit BCD 7-segment scanner with frame snapshot
module bcd_display_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bcd,
  input  logic        blank_all,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  anode,
  output logic        frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [6:0]    SEG_INV   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic          DP_INV    = (SEG_ACTIVE_LOW != 0);
  localparam logic [7:0]    AN_INV    = (AN_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   snap;
  logic          tick;
  logic          reload;
  logic          reload_d;
  // Holds the display dark between reset release and the first snapshot load,
  // so the reset-state digit 7 never flashes.
  logic          running;

  logic [3:0]    nib;
  logic [6:0]    seg_dec;
  logic          dp_dec;
  logic          lit;
  logic [7:0]    an_dec;

  assign tick   = (cnt == CNT_LAST);
  assign reload = tick && (idx == 3'd7);

  // Slot counter, digit index and frame snapshot
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= CNT_LAST;
      idx      <= 3'd7;
      snap     <= 32'hFFFF_FFFF;
      reload_d <= 1'b0;
      running  <= 1'b0;
    end else begin
      cnt      <= tick ? '0 : cnt + CW'(1);
      reload_d <= reload;
      if (tick) begin
        idx <= idx + 3'd1;
      end
      if (reload) begin
        snap    <= bcd;
        running <= 1'b1;
      end
    end
  end

  // Nibble decode and one-hot anode selection for the current slot
  always_comb begin
    nib     = snap[{idx, 2'b00} +: 4];
    seg_dec = 7'h00;
    dp_dec  = 1'b0;
    case (nib)
      4'h0: seg_dec = 7'h3F;
      4'h1: seg_dec = 7'h06;
      4'h2: seg_dec = 7'h5B;
      4'h3: seg_dec = 7'h4F;
      4'h4: seg_dec = 7'h66;
      4'h5: seg_dec = 7'h6D;
      4'h6: seg_dec = 7'h7D;
      4'h7: seg_dec = 7'h07;
      4'h8: seg_dec = 7'h7F;
      4'h9: seg_dec = 7'h6F;
      4'hA, 4'hB, 4'hC, 4'hD: seg_dec = 7'h40;
      4'hE: dp_dec = 1'b1;
      default: seg_dec = 7'h00;
    endcase
    lit    = running && !blank_all && (cnt >= BLANK_END);
    an_dec = lit ? (8'b1 << idx) : 8'h00;
  end

  // Registered, polarity-corrected pin drivers
  always_ff @(posedge clock) begin
    if (reset) begin
      seg         <= SEG_INV;
      dp          <= DP_INV;
      anode       <= AN_INV;
      frame_start <= 1'b0;
    end else begin
      seg         <= (running ? seg_dec : 7'h00) ^ SEG_INV;
      dp          <= (running && dp_dec) ^ DP_INV;
      anode       <= an_dec ^ AN_INV;
      frame_start <= reload_d;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb/tb_bcd_display_scan.sv - directed self-checking bench for bcd_display_scan
module tb_bcd_display_scan;

  logic        clock;
  logic        reset;
  logic [31:0] bcd;
  logic        blank_all;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  anode;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  // Expected segment patterns per frame, digit 7 leftmost in the concatenation.
  localparam logic [55:0] T76543210 = {7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  localparam logic [55:0] TSPECIAL  = {7'h00, 7'h00, 7'h00, 7'h00, 7'h06, 7'h00, 7'h5B, 7'h40};
  localparam logic [55:0] T12345678 = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F};
  localparam logic [55:0] T87654321 = {7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
  localparam logic [55:0] T24681357 = {7'h5B, 7'h66, 7'h7D, 7'h7F, 7'h06, 7'h4F, 7'h6D, 7'h07};

  bcd_display_scan #(
    .SCAN_DIV(4),
    .BLANK_CYC(1),
    .SEG_ACTIVE_LOW(0),
    .AN_ACTIVE_LOW(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bcd(bcd),
    .blank_all(blank_all),
    .seg(seg),
    .dp(dp),
    .anode(anode),
    .frame_start(frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, ".anode"}, anode, 8'h00);
    chk({tag, ".seg"}, {1'b0, seg}, 8'h00);
    chk({tag, ".dp"}, {7'b0, dp}, 8'h00);
    chk({tag, ".fs"}, {7'b0, frame_start}, 8'h00);
  endtask

  // Checks one 32-cycle frame starting at the frame_start sample; ends on the
  // next frame_start sample. Optionally changes bcd after cycle chg_k and
  // holds blank_all for 10 cycles after cycle blk_k.
  task automatic check_frame(input string name, input logic [55:0] segs, input logic [7:0] dps,
                             input int chg_k, input logic [31:0] chg_val, input int blk_k);
    for (int k = 0; k < 32; k++) begin
      int s;
      logic [7:0] exp_an;
      s = k / 4;
      exp_an = (k % 4 == 0) ? 8'h00 : (8'h01 << s);
      if (blk_k >= 0 && k > blk_k && k <= blk_k + 10) exp_an = 8'h00;
      chk($sformatf("%s.k%0d.fs", name, k), {7'b0, frame_start}, {7'b0, (k == 0)});
      chk($sformatf("%s.k%0d.anode", name, k), anode, exp_an);
      chk($sformatf("%s.k%0d.seg", name, k), {1'b0, seg}, {1'b0, segs[7*s +: 7]});
      chk($sformatf("%s.k%0d.dp", name, k), {7'b0, dp}, {7'b0, dps[s]});
      if (k == chg_k) bcd = chg_val;
      if (blk_k >= 0 && k == blk_k) blank_all = 1'b1;
      if (blk_k >= 0 && k == blk_k + 10) blank_all = 1'b0;
      tick();
    end
  endtask

  initial begin
    reset     = 1'b1;
    bcd       = 32'h7654_3210;
    blank_all = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk_dark($sformatf("rst%0d", i));
    end
    reset = 1'b0;
    tick();
    chk_dark("rel0");
    tick();

    check_frame("f76a", T76543210, 8'h00, -1, 32'h0, -1);
    bcd = 32'hFFFF_1E2A;
    check_frame("f76b", T76543210, 8'h00, -1, 32'h0, -1);
    bcd = 32'h1234_5678;
    check_frame("fspc", TSPECIAL, 8'h04, -1, 32'h0, -1);
    check_frame("f1234", T12345678, 8'h00, 13, 32'h8765_4321, -1);
    check_frame("f8765blk", T87654321, 8'h00, -1, 32'h0, 10);
    check_frame("f8765", T87654321, 8'h00, -1, 32'h0, -1);

    for (int i = 0; i < 21; i++) tick();
    chk("mid.anode_d5", anode, 8'h20);
    reset = 1'b1;
    bcd   = 32'h2468_1357;
    tick();
    chk_dark("mrst0");
    tick();
    chk_dark("mrst1");
    reset = 1'b0;
    tick();
    chk_dark("mrel0");
    tick();
    check_frame("f2468", T24681357, 8'h00, -1, 32'h0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
